// File: rtl/z80_dma_pkg.sv
// Shared definitions for the Z80 DMA bus controller: FSM state encoding and
// the default burst length per bus tenure.
package z80_dma_pkg;

    localparam int BURST_MAX_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD1,
        RD2,
        WR,
        REL,
        REL_WAIT
    } state_t;

endpackage

// File: rtl/z80_dma_addrgen.sv
// Source/destination pointers, remaining byte count and per-tenure burst
// counter for the DMA copy engine. Pointers wrap naturally at 16 bits.
module z80_dma_addrgen
    import z80_dma_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        burst_clr,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    output logic [15:0] cur_src,
    output logic [15:0] cur_dst,
    output logic [15:0] remaining,
    output logic        last,
    output logic        burst_full
);

    logic [7:0] burst_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_src   <= 16'h0000;
            cur_dst   <= 16'h0000;
            remaining <= 16'h0000;
            burst_cnt <= 8'h00;
        end else if (load) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
            burst_cnt <= 8'h00;
        end else begin
            if (step) begin
                cur_src   <= cur_src + 16'h0001;
                cur_dst   <= cur_dst + 16'h0001;
                remaining <= remaining - 16'h0001;
            end
            if (burst_clr)
                burst_cnt <= 8'h00;
            else if (step)
                burst_cnt <= burst_cnt + 8'h01;
        end
    end

    // Both flags look ahead to the values after the current write step.
    assign last       = (remaining == 16'h0001);
    assign burst_full = (({1'b0, burst_cnt} + 9'd1) == 9'(BURST_MAX));

endmodule

// File: rtl/z80_dma_busctl.sv
// Z80 DMA block-copy engine: requests the bus via busrq_n/busak_n, moves bytes
// with a 2-cycle read and 1-cycle write, and returns the bus every BURST_MAX bytes.
//
// state    | meaning
// IDLE     | waiting for start
// REQ      | busrq_n low, waiting for busak_n
// RD1      | read cycle, first half
// RD2      | read cycle, second half; data captured at end
// WR       | one-cycle write, pointers step
// REL      | bus released for one cycle
// REL_WAIT | wait for CPU to resume, give it one more cycle, then REQ
module z80_dma_busctl
    import z80_dma_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_own,
    output logic [15:0] dma_a,
    output logic [7:0]  dma_do,
    input  logic [7:0]  dma_di,
    output logic        dma_mreq_n,
    output logic        dma_rd_n,
    output logic        dma_wr_n
);

    state_t      state, state_nx;
    logic        gap, gap_nx;
    logic [7:0]  data_q;
    logic        done_nx, err_nx, capture;
    logic        load, step, burst_clr;
    logic [15:0] cur_src, cur_dst, remaining;
    logic        last, burst_full;

    z80_dma_addrgen #(.BURST_MAX(BURST_MAX)) u_addrgen (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .burst_clr  (burst_clr),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .cur_src    (cur_src),
        .cur_dst    (cur_dst),
        .remaining  (remaining),
        .last       (last),
        .burst_full (burst_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gap    <= 1'b0;
            data_q <= 8'h00;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            gap   <= gap_nx;
            done  <= done_nx;
            err   <= err_nx;
            if (capture)
                data_q <= dma_di;
        end
    end

    // Bus outputs are combinational so a lost busak_n drops them in the same cycle.
    always_comb begin
        state_nx   = state;
        gap_nx     = gap;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        capture    = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        burst_clr  = 1'b0;
        busrq_n    = 1'b1;
        bus_own    = 1'b0;
        dma_a      = 16'h0000;
        dma_do     = 8'h00;
        dma_mreq_n = 1'b1;
        dma_rd_n   = 1'b1;
        dma_wr_n   = 1'b1;
        case (state)
            IDLE: begin
                gap_nx = 1'b0;
                if (start) begin
                    load = 1'b1;
                    if (len != 16'h0000)
                        state_nx = REQ;
                    else
                        done_nx = 1'b1;
                end
            end
            REQ: begin
                busrq_n = 1'b0;
                if (!busak_n)
                    state_nx = RD1;
            end
            RD1, RD2: begin
                if (busak_n) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    busrq_n    = 1'b0;
                    bus_own    = 1'b1;
                    dma_a      = cur_src;
                    dma_mreq_n = 1'b0;
                    dma_rd_n   = 1'b0;
                    if (state == RD2) begin
                        capture  = 1'b1;
                        state_nx = WR;
                    end else begin
                        state_nx = RD2;
                    end
                end
            end
            WR: begin
                if (busak_n) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    busrq_n    = 1'b0;
                    bus_own    = 1'b1;
                    dma_a      = cur_dst;
                    dma_do     = data_q;
                    dma_mreq_n = 1'b0;
                    dma_wr_n   = 1'b0;
                    step       = 1'b1;
                    state_nx   = (last || burst_full) ? REL : RD1;
                end
            end
            REL: begin
                if (remaining == 16'h0000) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = REL_WAIT;
                end
            end
            REL_WAIT: begin
                if (gap) begin
                    gap_nx    = 1'b0;
                    burst_clr = 1'b1;
                    state_nx  = REQ;
                end else if (busak_n) begin
                    gap_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_z80_dma_busctl.sv
// Directed bench for z80_dma_busctl with a behavioural CPU (busrq/busak
// handshake, PC counter) and a 64 KiB byte memory on the DMA bus.
module tb_z80_dma_busctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src, dst, len;
    logic        busy, done, err;
    logic        busrq_n, busak_n, bus_own;
    logic [15:0] dma_a;
    logic [7:0]  dma_do, dma_di;
    logic        dma_mreq_n, dma_rd_n, dma_wr_n;

    always #5 clk = ~clk;

    z80_dma_busctl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .busrq_n    (busrq_n),
        .busak_n    (busak_n),
        .bus_own    (bus_own),
        .dma_a      (dma_a),
        .dma_do     (dma_do),
        .dma_di     (dma_di),
        .dma_mreq_n (dma_mreq_n),
        .dma_rd_n   (dma_rd_n),
        .dma_wr_n   (dma_wr_n)
    );

    // CPU: acknowledges one cycle after the request; PC runs only while it owns the bus.
    logic        cpu_ak = 1'b1;
    logic        busak_force = 1'b0;
    logic [15:0] pc = 16'h0000;
    assign busak_n = busak_force | cpu_ak;

    always @(posedge clk) begin
        cpu_ak <= busrq_n;
        if (busak_n)
            pc <= pc + 16'h0001;
    end

    logic [7:0]  mem [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_a = 16'h0000;
    logic [7:0]  poke_d = 8'h00;

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_a] <= poke_d;
        else if (!dma_mreq_n && !dma_wr_n)
            mem[dma_a] <= dma_do;
    end
    assign dma_di = mem[dma_a];

    int          done_cnt = 0, err_cnt = 0, busy_cnt = 0, busrq_low_cnt = 0;
    int          own_violation = 0, idle_violation = 0, tenure_cnt = 0, wr_in_ten = 0;
    logic        own_prev = 1'b0, rd_prev = 1'b1;
    logic [15:0] fall_pc = 16'h0000;
    int          ten_bytes[$];
    int          gap_adv[$];
    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];

    always @(negedge clk) begin
        if (reset) begin
            own_prev = 1'b0;
            rd_prev  = 1'b1;
        end else begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if (!busrq_n) busrq_low_cnt++;
            if (bus_own && busak_n) own_violation++;
            if (!bus_own && ({dma_mreq_n, dma_rd_n, dma_wr_n} !== 3'b111 ||
                             dma_a !== 16'h0000 || dma_do !== 8'h00))
                idle_violation++;
            if (bus_own && !own_prev) begin
                tenure_cnt++;
                wr_in_ten = 0;
                gap_adv.push_back(int'(pc - fall_pc));
            end
            if (!dma_mreq_n && !dma_rd_n && rd_prev)
                rd_log.push_back(dma_a);
            if (!dma_mreq_n && !dma_wr_n) begin
                wr_log.push_back(dma_a);
                wr_in_ten++;
            end
            if (!bus_own && own_prev) begin
                ten_bytes.push_back(wr_in_ten);
                fall_pc = pc;
            end
            own_prev = bus_own;
            rd_prev  = dma_rd_n;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, t0, w0, r0, b0, q0, tb0, gb0, bad, nw;
        logic rd_seen;

        reset = 1'b1;
        start = 1'b0;
        src   = 16'h0000;
        dst   = 16'h0000;
        len   = 16'h0000;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_bus_own", 32'(bus_own), 32'd0);
        check("rst_busrq_n", 32'(busrq_n), 32'd1);
        check("rst_strobes", 32'({dma_mreq_n, dma_rd_n, dma_wr_n}), 32'h7);
        check("rst_addr_data", 32'({dma_a, dma_do}), 32'd0);
        reset = 1'b0;
        tick();

        // Three-byte copy in one tenure; a second start while busy is ignored.
        poke(16'h0100, 8'h11);
        poke(16'h0101, 8'h22);
        poke(16'h0102, 8'h33);
        poke(16'h0203, 8'hEE);
        d0 = done_cnt; e0 = err_cnt; t0 = tenure_cnt; w0 = wr_log.size();
        launch(16'h0100, 16'h0200, 16'd3);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_busrq_low", 32'(busrq_n), 32'd0);
        tick();
        launch(16'h0500, 16'h0203, 16'd7);
        wait_done(100, "t1_done_seen");
        check("t1_busy_falls_with_done", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check("t1_byte0", 32'(mem[16'h0200]), 32'h11);
        check("t1_byte1", 32'(mem[16'h0201]), 32'h22);
        check("t1_byte2", 32'(mem[16'h0202]), 32'h33);
        check("t1_no_extra_write", 32'(mem[16'h0203]), 32'hEE);
        check("t1_tenures", 32'(tenure_cnt - t0), 32'd1);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_err_pulses", 32'(err_cnt - e0), 32'd0);
        check("t1_writes", 32'(wr_log.size() - w0), 32'd3);

        // 40 bytes with the default burst of 16: tenures of 16, 16 and 8.
        for (int i = 0; i < 40; i++)
            poke(16'h1000 + 16'(i), 8'(i) ^ 8'h5A);
        d0 = done_cnt; t0 = tenure_cnt; tb0 = ten_bytes.size(); gb0 = gap_adv.size();
        launch(16'h1000, 16'h2000, 16'd40);
        wait_done(600, "t2_done_seen");
        tick(); tick(); tick();
        check("t2_tenures", 32'(tenure_cnt - t0), 32'd3);
        check("t2_burst0", 32'(ten_bytes[tb0]), 32'd16);
        check("t2_burst1", 32'(ten_bytes[tb0 + 1]), 32'd16);
        check("t2_burst2", 32'(ten_bytes[tb0 + 2]), 32'd8);
        check("t2_cpu_ran_gap1", 32'(gap_adv[gb0 + 1] >= 1), 32'd1);
        check("t2_cpu_ran_gap2", 32'(gap_adv[gb0 + 2] >= 1), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++)
            if (mem[16'h2000 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
        check("t2_data_errors", 32'(bad), 32'd0);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Pointer wrap at FFFF.
        poke(16'hFFFE, 8'hA1);
        poke(16'hFFFF, 8'hA2);
        poke(16'h0000, 8'hA3);
        poke(16'h0001, 8'hA4);
        r0 = rd_log.size(); w0 = wr_log.size();
        launch(16'hFFFE, 16'h0010, 16'd4);
        wait_done(100, "t3_done_seen");
        tick(); tick();
        check("t3_rd0", 32'(rd_log[r0]), 32'hFFFE);
        check("t3_rd1", 32'(rd_log[r0 + 1]), 32'hFFFF);
        check("t3_rd2", 32'(rd_log[r0 + 2]), 32'h0000);
        check("t3_rd3", 32'(rd_log[r0 + 3]), 32'h0001);
        check("t3_wr0", 32'(wr_log[w0]), 32'h0010);
        check("t3_wr3", 32'(wr_log[w0 + 3]), 32'h0013);
        check("t3_data_last", 32'(mem[16'h0013]), 32'hA4);
        check("t3_data_first", 32'(mem[16'h0010]), 32'hA1);

        // Zero-length copy completes immediately without touching the bus.
        d0 = done_cnt; b0 = busy_cnt; q0 = busrq_low_cnt;
        launch(16'h0100, 16'h0300, 16'd0);
        check("t4_done_next_cycle", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_busrq_n", 32'(busrq_n), 32'd1);
        tick(); tick(); tick();
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_busy_cycles", 32'(busy_cnt - b0), 32'd0);
        check("t4_busrq_low_cycles", 32'(busrq_low_cnt - q0), 32'd0);

        // Reset during the second write of a 5-byte copy.
        for (int i = 0; i < 5; i++)
            poke(16'h0300 + 16'(i), 8'(i + 1));
        poke(16'h0400, 8'h00);
        poke(16'h0401, 8'h66);
        d0 = done_cnt; e0 = err_cnt;
        launch(16'h0300, 16'h0400, 16'd5);
        nw = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!dma_mreq_n && !dma_wr_n) nw++;
            if (nw == 2) break;
        end
        check("t5_second_write_reached", 32'(nw), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check("t5_busrq_n_async", 32'(busrq_n), 32'd1);
        check("t5_bus_own_async", 32'(bus_own), 32'd0);
        check("t5_busy_async", 32'(busy), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("t5_first_byte", 32'(mem[16'h0400]), 32'h01);
        check("t5_second_untouched", 32'(mem[16'h0401]), 32'h66);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);

        // busak_n lost during RD2.
        poke(16'h0600, 8'h77);
        poke(16'h0700, 8'h55);
        d0 = done_cnt; e0 = err_cnt;
        launch(16'h0600, 16'h0700, 16'd1);
        rd_seen = 1'b0;
        nw = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!dma_rd_n && rd_seen) begin
                nw = 1;
                break;
            end
            rd_seen = !dma_rd_n;
        end
        check("t6_rd2_reached", 32'(nw), 32'd1);
        busak_force = 1'b1;
        #1;
        check("t6_strobes_released", 32'({dma_mreq_n, dma_rd_n, dma_wr_n}), 32'h7);
        check("t6_bus_own", 32'(bus_own), 32'd0);
        check("t6_busrq_n", 32'(busrq_n), 32'd1);
        @(posedge clk);
        #1;
        check("t6_err_pulse", 32'(err), 32'd1);
        check("t6_idle", 32'(busy), 32'd0);
        busak_force = 1'b0;
        tick();
        check("t6_err_one_cycle", 32'(err), 32'd0);
        tick(); tick();
        check("t6_dst_unchanged", 32'(mem[16'h0700]), 32'h55);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_err_count", 32'(err_cnt - e0), 32'd1);

        check("bus_own_only_with_busak", 32'(own_violation), 32'd0);
        check("idle_bus_quiet", 32'(idle_violation), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_dma_busctl.md
Z80_DMA_BUSCTL -- requirements
Module: z80_dma_busctl

Interface
REQ-001 Parameter BURST_MAX, default 16, SHALL set the maximum bytes moved per bus tenure before the bus is returned to the CPU (range 1..255).
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that launches a block copy; sampled only in IDLE.
REQ-005 src / dst  in  16 / 16  source and destination byte addresses, latched on start.
REQ-006 len  in  16  byte count, latched on start; 0 is legal.
REQ-007 busy  out  1  high from the cycle after an accepted start until done.
REQ-008 done  out  1  one-cycle pulse at copy completion.
REQ-009 err  out  1  one-cycle pulse on bus protocol violation.
REQ-010 busrq_n  out  1  to CPU busrq_n, active low.
REQ-011 busak_n  in  1  from CPU busak_n, active low.
REQ-012 bus_own  out  1  high while the block drives the memory bus; this is the external A/dout/mreq_n/rd_n/wr_n mux select.
REQ-013 dma_a  out  16  memory address.
REQ-014 dma_do  out  8  write data.
REQ-015 dma_di  in  8  read data.
REQ-016 dma_mreq_n / dma_rd_n / dma_wr_n  out  1 each  memory strobes, active low.

Function
REQ-017 FSM states SHALL be: IDLE, REQ, RD1, RD2, WR, REL, REL_WAIT.
REQ-018 IDLE + start with len≠0 -> REQ; busrq_n=0 from REQ until leaving the tenure.
REQ-019 IDLE + start with len=0 -> done pulse in the next cycle, busy stays 0, busrq_n stays 1.
REQ-020 REQ: wait until busak_n=0, then go to RD1; bus_own=1 from RD1 until entry to REL.
REQ-021 RD1 and RD2 SHALL both drive dma_a=cur_src, dma_mreq_n=0 and dma_rd_n=0; dma_di is captured into the data register at the end of RD2.
REQ-022 WR SHALL drive dma_a=cur_dst, dma_do=data register, dma_mreq_n=0 and dma_wr_n=0 for exactly one cycle; then cur_src+1, cur_dst+1, remaining-1 and burst count+1.
REQ-023 The src and dst pointers SHALL wrap modulo 2^16 (FFFF+1 -> 0000).
REQ-024 After WR:
  - remaining=0 -> REL, then done.
  - else burst count=BURST_MAX -> REL then REL_WAIT.
  - else RD1.
REQ-025 REL SHALL drive bus_own=0, busrq_n=1 and all strobes high for one cycle.
REQ-026 REL_WAIT SHALL wait for busak_n=1, hold busrq_n=1 for one further cycle so the CPU executes at least one M-cycle, reset the burst count, then go to REQ.
REQ-027 Completion: done pulses in the cycle after REL; FSM returns to IDLE; busy falls with done.
REQ-028 busak_n=1 observed in any of RD1, RD2 or WR SHALL:
  - pulse err;
  - release all strobes and bus_own at once;
  - set busrq_n=1;
  - return to IDLE without done.
REQ-029 A start while busy SHALL be ignored.
REQ-030 When bus_own=0, all strobes SHALL be 1 and dma_a/dma_do SHALL be 0.

Reset
REQ-031 While reset=1, and asynchronously on its assertion, the block SHALL force:
  - state=IDLE; busy=done=err=0; bus_own=0;
  - busrq_n=1; dma_mreq_n=dma_rd_n=dma_wr_n=1; dma_a=0; dma_do=0;
  - all counters and pointers to 0.
REQ-032 Reset mid-transfer SHALL abandon the copy with no done or err pulse; bytes already written stay written.

Structure
REQ-033 Package z80_dma_pkg SHALL hold the state enum and the BURST_MAX default constant.
REQ-034 Sub-module z80_dma_addrgen SHALL hold the src/dst pointers and the remaining and burst counters, with load/step controls; the FSM stays in the top module.

Verification
REQ-035 src=0100, dst=0200, len=3, mem[0100..0102]=11,22,33 -> mem[0200..0202]=11,22,33; exactly one tenure; one done pulse; CPU PC frozen while busak_n=0.
REQ-036 len=40, BURST_MAX=16 -> three tenures of 16, 16 and 8 bytes; busak_n returns high between tenures; CPU advances at least one M-cycle in each gap.
REQ-037 src=FFFE, dst=0010, len=4 -> reads from FFFE, FFFF, 0000, 0001; writes to 0010..0013.
REQ-038 len=0 -> done one cycle after start; busrq_n never low; busy never high.
REQ-039 reset asserted in the 2nd WR of a len=5 copy -> busrq_n=1 and bus_own=0 in the same cycle; only the first byte is copied; no done pulse.
REQ-040 busak_n forced high during RD2 -> err pulse, strobes released, return to IDLE, destination unchanged.
